sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, parametrised FIFO built around an internal dual-port register array. It is the next generation of the team's FIFO memory: it adds its own pointer management, registered read data, occupancy count, programmable almost-full and almost-empty thresholds, and error pulses for overflow and underflow. It sits between producer and consumer logic within one clock domain. It is the same-domain counterpart of the asynchronous FIFO.

## Interface
Parameters:
- DATA_SIZE, 8, word width in bits.
- ADDR_SIZE, 4, address width; depth = 2^ADDR_SIZE words.
- AFULL_THRESH, 12, almost_full asserts when count >= AFULL_THRESH; legal range 1..2^ADDR_SIZE.
- AEMPTY_THRESH, 2, almost_empty asserts when count <= AEMPTY_THRESH; legal range 0..2^ADDR_SIZE-1.

Ports:
- clk, input, 1, the single clock; all state updates on its rising edge.
- rst, input, 1, synchronous, active-high reset.
- wr_en, input, 1, write request.
- wr_data, input, DATA_SIZE, write word.
- rd_en, input, 1, read request (pop).
- rd_data, output, DATA_SIZE, read word.
- rd_valid, output, 1, rd_data holds a valid popped word.
- full, output, 1, count == 2^ADDR_SIZE.
- empty, output, 1, count == 0.
- almost_full, output, 1, threshold flag.
- almost_empty, output, 1, threshold flag.
- count, output, ADDR_SIZE+1, current occupancy, 0..2^ADDR_SIZE.
- overflow, output, 1, one-cycle pulse: a write was rejected.
- underflow, output, 1, one-cycle pulse: a read was rejected.

## Operation
- wr_ptr and rd_ptr are binary counters, each ADDR_SIZE+1 bits wide.
  - The low ADDR_SIZE bits address the memory; the MSB is the wrap bit.
  - count = wr_ptr - rd_ptr, computed modulo 2^(ADDR_SIZE+1).
  - full: MSBs differ and low bits are equal. empty: pointers are equal.
- Read accepted (rd_acc) = rd_en && !empty.
- Write accepted (wr_acc) = wr_en && (!full || rd_acc). A write while full is accepted if a read is accepted in the same cycle.
- Write while empty with rd_en: the write is accepted, the read is rejected, and underflow pulses.
- wr_acc: mem[wr_ptr] <= wr_data, then wr_ptr increments. rd_acc: rd_ptr increments.
- Pointers wrap naturally at 2^(ADDR_SIZE+1); the memory address wraps at 2^ADDR_SIZE.
- Rejected write (wr_en && !wr_acc) → overflow = 1 in the next cycle. Rejected read (rd_en && empty) → underflow = 1 in the next cycle. Neither rejection changes state.
- Flag and count outputs decode only registered pointers. There is no combinational path from inputs to outputs except as stated under Configuration.
- Memory contents are not reset.

## Timing
- Reset values: empty = 1, full = 0, count = 0, almost_empty = 1, almost_full = 0, rd_data = 0, rd_valid = 0, overflow = 0, underflow = 0. Both pointers = 0.
- Reset mid-operation:
  - All of the above take effect on the next edge; a pending rd_valid is dropped.
  - Stale memory words are unreachable afterwards.
  - A wr_en or rd_en sampled in the reset cycle is ignored and raises no error pulse.
- Standard mode: rd_acc at edge N → rd_data = mem[rd_ptr] and rd_valid = 1 after edge N. rd_valid is 0 in cycles without rd_acc; rd_data holds its last value.
- A write at edge N updates count, empty, full and both almost-flags after edge N. The earliest pop of that word is at edge N+1, with data visible after N+1.
- Simultaneous accepted read and write: count is unchanged and all flags hold.

## Configuration
- FIFO_FWFT_EN defined (first-word fall-through):
  - rd_data = mem[rd_ptr[ADDR_SIZE-1:0]], read combinationally from the registered pointer.
  - rd_valid = !empty.
  - rd_acc consumes the displayed word; the next word is shown after the edge.
  - A word written at edge N appears on rd_data after edge N. Latency from rd_en is 0.
  - The rd_data reset value is undefined; rd_valid is 0 in reset.
- FIFO_FWFT_EN undefined: standard registered-read behaviour as described above, with 1-cycle read latency.

## Test plan
- Reset, then write 16 words 0x00..0x0F with DATA_SIZE 8 and ADDR_SIZE 4 → full = 1 and count = 16. almost_full rises after the 12th write. A 17th write → overflow pulses for 1 cycle, count stays 16.
- Read all 16 → rd_data sequence 0x00..0x0F, each with rd_valid 1 cycle after its rd_en. empty = 1 after the last read. An extra read → underflow pulses for 1 cycle and rd_valid = 0.
- Wrap: 3 rounds of 10 writes followed by 10 reads → data order preserved across the pointer wrap, count returns to 0 each round.
- Full with simultaneous wr_en and rd_en → both accepted, count stays 16, no overflow; the popped word is the oldest.
- Empty with simultaneous wr_en and rd_en → write accepted, underflow pulses, count = 1, rd_valid = 0.
- Assert rst with count = 7 → next cycle count = 0, empty = 1, rd_valid = 0. With FIFO_FWFT_EN: a write of 0xA5 into the empty FIFO shows rd_data = 0xA5 and rd_valid = 1 one edge later.

Source files
------------

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers, occupancy count, threshold flags
// and overflow/underflow pulses. Define FIFO_FWFT_EN for first-word fall-through reads.
module sync_fifo #(
  parameter int unsigned DATA_SIZE     = 8,
  parameter int unsigned ADDR_SIZE     = 4,
  parameter int unsigned AFULL_THRESH  = 12,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_SIZE:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int unsigned        DEPTH      = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] AFULL_LVL  = AFULL_THRESH[ADDR_SIZE:0];
  localparam logic [ADDR_SIZE:0] AEMPTY_LVL = AEMPTY_THRESH[ADDR_SIZE:0];
  localparam logic [ADDR_SIZE:0] PTR_ONE    = {{ADDR_SIZE{1'b0}}, 1'b1};

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [ADDR_SIZE:0]   wr_ptr, rd_ptr;
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
  logic                 rd_acc, wr_acc;

  assign wr_addr = wr_ptr[ADDR_SIZE-1:0];
  assign rd_addr = rd_ptr[ADDR_SIZE-1:0];

  // Flags decode registered pointers only; the wrap bit separates full from empty.
  assign count        = wr_ptr - rd_ptr;
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[ADDR_SIZE] != rd_ptr[ADDR_SIZE]) && (wr_addr == rd_addr);
  assign almost_full  = (count >= AFULL_LVL);
  assign almost_empty = (count <= AEMPTY_LVL);

  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  // NOTE: non-blocking assignments make every register sample pre-edge values, so the
  // pointer updates and error pulses below are order-independent.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      overflow  <= wr_en && !wr_acc;
      underflow <= rd_en && empty;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone decide which
  // words are live, so stale contents are unreachable after a reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[wr_addr] <= wr_data;
  end

`ifdef FIFO_FWFT_EN
  assign rd_data  = mem[rd_addr];
  assign rd_valid = !empty;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) rd_data <= mem[rd_addr];
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: scoreboard bench for sync_fifo; expected words are queued on accepted
// writes and popped on accepted reads. Honours FIFO_FWFT_EN like the design.
module tb_sync_fifo;

  localparam int DEPTH  = 16;
  localparam int AFULL  = 12;
  localparam int AEMPTY = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  logic [7:0] sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  sync_fifo #(
    .DATA_SIZE(8), .ADDR_SIZE(4), .AFULL_THRESH(AFULL), .AEMPTY_THRESH(AEMPTY)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_flags();
    int n;
    n = sb.size();
    check("count", 32'(count), 32'(n));
    check("empty", 32'(empty), 32'(n == 0));
    check("full", 32'(full), 32'(n == DEPTH));
    check("almost_full", 32'(almost_full), 32'(n >= AFULL));
    check("almost_empty", 32'(almost_empty), 32'(n <= AEMPTY));
`ifdef FIFO_FWFT_EN
    check("fwft_valid", 32'(rd_valid), 32'(n != 0));
    if (n != 0) check("fwft_data", 32'(rd_data), 32'(sb[0]));
`endif
  endtask

  // One clock of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic cycle(input logic we, input logic [7:0] wd, input logic re);
    logic       racc, wacc;
    logic [7:0] exp_rd;
    racc = re && (sb.size() != 0);
    wacc = we && ((sb.size() != DEPTH) || racc);
    wr_en = we; wr_data = wd; rd_en = re;
`ifdef FIFO_FWFT_EN
    if (racc) check("fwft_head", 32'(rd_data), 32'(sb[0]));
`endif
    exp_rd = 8'h00;
    if (racc) exp_rd = sb.pop_front();
    if (wacc) sb.push_back(wd);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    check("overflow", 32'(overflow), 32'(we && !wacc));
    check("underflow", 32'(underflow), 32'(re && !racc));
`ifndef FIFO_FWFT_EN
    check("rd_valid", 32'(rd_valid), 32'(racc));
    if (racc) check("rd_data", 32'(rd_data), 32'(exp_rd));
`endif
    check_flags();
  endtask

  task automatic do_reset(input logic we, input logic re);
    rst = 1'b1; wr_en = we; rd_en = re; wr_data = 8'h5A;
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    sb.delete();
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
`ifndef FIFO_FWFT_EN
    check("rst_rd_data", 32'(rd_data), 32'd0);
`endif
    check_flags();
  endtask

  initial begin
    do_reset(1'b0, 1'b0);
    do_reset(1'b0, 1'b0);

    // Fill to full, then one rejected write.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0);
    cycle(1'b1, 8'hEE, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);

    // Drain, then one rejected read.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    // Pointer wrap rounds.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h40 + r * 16 + i), 1'b0);
      for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1);
    end

    // Simultaneous read and write while full.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0);
    cycle(1'b1, 8'hC3, 1'b1);
    cycle(1'b1, 8'hC4, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1);

    // Simultaneous read and write while empty.
    cycle(1'b1, 8'h3C, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    // Reset with 7 words stored and requests pending.
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
    do_reset(1'b1, 1'b1);
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
